alu_shift_sequencer: RTL and testbench
======================================

// Module: alu_shift_sequencer
// PURPOSE
//  Upstream/downstream sequencer for the ALU's combinational logical right shifter (8-bit data, 3-bit amount).
//  Captures the operand and the shift amount as two successive bytes on one shared 8-bit input bus.
//  Holds both stable on the shifter's inputs and registers the shifter's output.
//  Presents the registered result with a valid/ready handshake, so a pin-limited top level can drive the shifter.
// PARAMETERS
//  WIDTH  8  data width of operand, shifter output and result
//  AMT_W  3  shift-amount width; taken from din[AMT_W-1:0]
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  din        in   WIDTH  shared input bus: 1st beat = operand, 2nd beat = shift amount
//  din_valid  in   1      din beat offered
//  din_ready  out  1      beat accepted when din_valid && din_ready at clk edge
//  abort      in   1      synchronous cancel of the current operation
//  op_data    out  WIDTH  registered operand, drives shifter data input
//  op_amt     out  AMT_W  registered amount, drives shifter amount input
//  shift_res  in   WIDTH  shifter output, combinational from op_data/op_amt
//  res        out  WIDTH  registered result
//  res_zero   out  1      registered: res == 0
//  res_valid  out  1      result available
//  res_ready  in   1      consumer takes result when res_valid && res_ready at clk edge
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, immediate, not clock-gated):
//   state=IDLE; op_data=0, op_amt=0, res=0, res_zero=0, res_valid=0.
//   din_ready=1 (combinational from state); busy=0.
//  FSM states: IDLE, GET_AMT, EVAL, HOLD.
//   IDLE:    din_ready=1. On beat: op_data<=din; ->GET_AMT.
//   GET_AMT: din_ready=1. On beat: op_amt<=din[AMT_W-1:0] (upper bits ignored); ->EVAL.
//   EVAL:    din_ready=0. One cycle for shifter settling. At edge: res<=shift_res, res_zero<=(shift_res==0); ->HOLD.
//   HOLD:    res_valid=1, din_ready=0. On res_ready: ->IDLE; res_valid low the next cycle.
//  din_valid low in IDLE/GET_AMT: state and registers hold; gaps of any length are allowed.
//  Latency: amount beat accepted at edge M -> res_valid high in cycle M+2 (2 edges). Minimum 4 cycles per operation incl. handshake.
//  res/res_zero stay stable while res_valid=1 and retain their value after the handshake until the next EVAL.
//  op_data/op_amt stay stable from capture until overwritten by the next accepted beat.
//  din_valid during EVAL/HOLD is ignored (din_ready=0); no beat is lost or queued.
//  abort (sync), evaluated at each edge:
//   -> IDLE from any state; res_valid<=0; op_data, op_amt, res untouched.
//   Overrides a same-edge beat acceptance and a same-edge res_ready (not counted as consumed).
//  Priority: rst > abort > handshake transitions.
//  Reset mid-operation: all state discarded immediately; no partial result emitted after release.
//  Widths: op_amt range 0..2^AMT_W-1. Amount 0 gives res = op_data. No arithmetic is done here; the shift is external.
// TESTING (bench instantiates the shifter model: shift_res = op_data >> op_amt)
//  T1 beats 0xB4 then 0x03, res_ready=1 -> res=0x16, res_zero=0, res_valid exactly 1 cycle, 2 edges after 2nd beat.
//  T2 beats 0xB4,0x00 -> res=0xB4. Beats 0xB4,0xFD -> op_amt=5, res=0x05. Beats 0x80,0x07 -> res=0x01.
//     Beats 0x07,0x03 -> res=0x00, res_zero=1.
//  T3 res_ready low 10 cycles in HOLD, din_valid=1 with junk -> res_valid=1, res stable, din_ready=0, op_* unchanged.
//     Then res_ready=1 -> IDLE.
//  T4 idle gaps: 5 cycles between beats, din_valid low -> same result as T1. Back-to-back ops give correct independent results.
//  T5 abort in GET_AMT, in EVAL, and in HOLD with res_ready=1 same edge -> IDLE next cycle, res_valid=0.
//     A following op completes normally.
//  T6 rst pulsed between edges in HOLD -> res_valid, res, op_* = 0 before the next edge.
//     After release, state IDLE and din_ready=1.

Source files
------------

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: feeds an external right shifter from a shared byte bus and returns the registered result over valid/ready
module alu_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] op_data,
  output logic [AMT_W-1:0] op_amt,
  input  logic [WIDTH-1:0] shift_res,
  output logic [WIDTH-1:0] res,
  output logic             res_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, GET_AMT, EVAL, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] op_data_q, op_data_d, res_q, res_d;
  logic [AMT_W-1:0] op_amt_q, op_amt_d;
  logic res_zero_q, res_zero_d;
  logic take;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_data_q  <= '0;
      op_amt_q   <= '0;
      res_q      <= '0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_data_q  <= op_data_d;
      op_amt_q   <= op_amt_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
    end
  end
  // abort wins over any same-edge beat or result handshake
  always_comb begin
    take       = din_valid && din_ready && !abort;
    state_d    = abort                              ? IDLE    :
                 (state_q == IDLE    && take)       ? GET_AMT :
                 (state_q == GET_AMT && take)       ? EVAL    :
                 (state_q == EVAL)                  ? HOLD    :
                 (state_q == HOLD    && res_ready)  ? IDLE    : state_q;
    op_data_d  = (state_q == IDLE && take) ? din : op_data_q;
    op_amt_d   = (state_q == GET_AMT && take) ? din[AMT_W-1:0] : op_amt_q;
    res_d      = (state_q == EVAL && !abort) ? shift_res : res_q;
    res_zero_d = (state_q == EVAL && !abort) ? (shift_res == '0) : res_zero_q;
  end
  always_comb begin
    din_ready = (state_q == IDLE) || (state_q == GET_AMT);
    res_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
  end
  assign op_data  = op_data_q;
  assign op_amt   = op_amt_q;
  assign res      = res_q;
  assign res_zero = res_zero_q;
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb_alu_shift_sequencer: directed vectors against alu_shift_sequencer with a behavioural right shifter
module tb_alu_shift_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] din = '0, op_data, shift_res, res;
  logic [2:0] op_amt;
  logic din_valid = 1'b0, din_ready, abort = 1'b0, res_zero, res_valid, res_ready = 1'b0, busy;
  int total = 0, bad = 0;
  alu_shift_sequencer dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .abort(abort), .op_data(op_data), .op_amt(op_amt), .shift_res(shift_res),
    .res(res), .res_zero(res_zero), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );
  assign shift_res = op_data >> op_amt;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] v);
    din = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] er, input logic ez);
    res_ready = 1'b1;
    beat(a);
    check("op_data", op_data, a);
    beat(b);
    check("op_amt", op_amt, b & 8'h07);
    check("eval_valid", res_valid, 0);
    check("eval_ready", din_ready, 0);
    tick();
    check("hold_valid", res_valid, 1);
    check("res", res, er);
    check("res_zero", res_zero, ez);
    tick();
    check("after_valid", res_valid, 0);
    check("after_busy", busy, 0);
    check("after_res", res, er);
  endtask
  initial begin
    #1;
    check("rst_valid", res_valid, 0);
    check("rst_ready", din_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    check("rst_opd", op_data, 0);
    check("rst_zero", res_zero, 0);
    #12 rst = 1'b0;
    tick();
    // T1/T2 basic shifts and boundary amounts
    op(8'hB4, 8'h03, 8'h16, 1'b0);
    op(8'hB4, 8'h00, 8'hB4, 1'b0);
    op(8'hB4, 8'hFD, 8'h05, 1'b0);
    op(8'h80, 8'h07, 8'h01, 1'b0);
    op(8'h07, 8'h03, 8'h00, 1'b1);
    // T3 stall in HOLD with junk on din
    res_ready = 1'b0;
    beat(8'h96);
    beat(8'h02);
    tick();
    din = 8'h5A;
    din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", res_valid, 1);
      check("stall_res", res, 8'h25);
      check("stall_ready", din_ready, 0);
      check("stall_opd", op_data, 8'h96);
      check("stall_amt", op_amt, 2);
      tick();
    end
    din_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    check("stall_rel_busy", busy, 0);
    check("stall_rel_valid", res_valid, 0);
    check("stall_rel_res", res, 8'h25);
    // T4 gaps between beats, then back-to-back
    beat(8'hB4);
    for (int i = 0; i < 5; i++) tick();
    check("gap_busy", busy, 1);
    check("gap_ready", din_ready, 1);
    check("gap_opd", op_data, 8'hB4);
    beat(8'h03);
    tick();
    check("gap_valid", res_valid, 1);
    check("gap_res", res, 8'h16);
    tick();
    op(8'hF0, 8'h04, 8'h0F, 1'b0);
    op(8'h01, 8'h00, 8'h01, 1'b0);
    // T5 abort in GET_AMT (overrides beat), EVAL and HOLD
    beat(8'h55);
    din = 8'h02;
    din_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    din_valid = 1'b0;
    check("abort_ga_busy", busy, 0);
    check("abort_ga_amt", op_amt, 0);
    check("abort_ga_valid", res_valid, 0);
    beat(8'h40);
    beat(8'h01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ev_busy", busy, 0);
    check("abort_ev_res", res, 8'h01);
    check("abort_ev_valid", res_valid, 0);
    beat(8'h40);
    beat(8'h01);
    tick();
    check("abort_h_pre", res_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_h_busy", busy, 0);
    check("abort_h_valid", res_valid, 0);
    check("abort_h_res", res, 8'h20);
    op(8'hC3, 8'h01, 8'h61, 1'b0);
    // T6 asynchronous reset in HOLD
    res_ready = 1'b0;
    beat(8'h81);
    beat(8'h01);
    tick();
    check("pre_rst_res", res, 8'h40);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", res_valid, 0);
    check("arst_res", res, 0);
    check("arst_opd", op_data, 0);
    check("arst_amt", op_amt, 0);
    #1 rst = 1'b0;
    check("arst_ready", din_ready, 1);
    check("arst_busy", busy, 0);
    tick();
    check("arst_post_valid", res_valid, 0);
    op(8'hFF, 8'h07, 8'h01, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
